morra_match_scoreboard: RTL

- Downstream consumer of the MorraCinese game FSMD.
- Samples the FSMD's per-cycle ROUND and GAME result codes, plus the START it is driven with, and accumulates per-game round statistics and match-level game tallies.
- Declares the match winner once a player reaches the win target or the game budget is exhausted.
- Feeds the display/report logic.

---
 rtl/morra_match_scoreboard.sv | 138 +++++++++++++
 1 files changed

// File: rtl/morra_match_scoreboard.sv
// Match scoreboard for the MorraCinese FSMD. It tallies the rounds in each game
// and the games in each match, then latches the match winner.
module morra_match_scoreboard #(
    parameter int unsigned GAMES_TO_WIN = 2,
    parameter int unsigned MAX_GAMES    = 3,
    parameter int unsigned CW           = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          match_clear,
    input  logic [1:0]    round,
    input  logic [1:0]    game,
    output logic [CW-1:0] rounds_played,
    output logic [CW-1:0] p1_rounds,
    output logic [CW-1:0] p2_rounds,
    output logic [CW-1:0] draw_rounds,
    output logic [CW-1:0] p1_games,
    output logic [CW-1:0] p2_games,
    output logic [CW-1:0] draw_games,
    output logic          game_done,
    output logic          match_over,
    output logic [1:0]    match_winner
);

    typedef enum logic [1:0] {
        IDLE,
        IN_GAME,
        MATCH_OVER
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] WIN_T   = CW'(GAMES_TO_WIN);
    localparam logic [CW+1:0] MAX_T   = (CW+2)'(MAX_GAMES);

    state_t state;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Post-increment game tallies; the match decision is taken on these values.
    logic [CW-1:0] p1g_nx, p2g_nx, dg_nx;
    logic [CW+1:0] total_nx;
    logic [1:0]    budget_winner;

    always_comb begin
        p1g_nx = p1_games;
        p2g_nx = p2_games;
        dg_nx  = draw_games;
        case (game)
            2'b01:   p1g_nx = sat_inc(p1_games);
            2'b10:   p2g_nx = sat_inc(p2_games);
            2'b11:   dg_nx  = sat_inc(draw_games);
            default: ;
        endcase
        total_nx = {2'b00, p1g_nx} + {2'b00, p2g_nx} + {2'b00, dg_nx};
        if (p1g_nx > p2g_nx)
            budget_winner = 2'b01;
        else if (p2g_nx > p1g_nx)
            budget_winner = 2'b10;
        else
            budget_winner = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst || match_clear) begin
            state         <= IDLE;
            rounds_played <= '0;
            p1_rounds     <= '0;
            p2_rounds     <= '0;
            draw_rounds   <= '0;
            p1_games      <= '0;
            p2_games      <= '0;
            draw_games    <= '0;
            game_done     <= 1'b0;
            match_over    <= 1'b0;
            match_winner  <= 2'b00;
        end else begin
            game_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rounds_played <= '0;
                        p1_rounds     <= '0;
                        p2_rounds     <= '0;
                        draw_rounds   <= '0;
                        state         <= IN_GAME;
                    end
                end

                IN_GAME: begin
                    if (start) begin
                        rounds_played <= '0;
                        p1_rounds     <= '0;
                        p2_rounds     <= '0;
                        draw_rounds   <= '0;
                    end else begin
                        if (round != 2'b00) begin
                            rounds_played <= sat_inc(rounds_played);
                            case (round)
                                2'b01:   p1_rounds   <= sat_inc(p1_rounds);
                                2'b10:   p2_rounds   <= sat_inc(p2_rounds);
                                default: draw_rounds <= sat_inc(draw_rounds);
                            endcase
                        end
                        if (game != 2'b00) begin
                            p1_games   <= p1g_nx;
                            p2_games   <= p2g_nx;
                            draw_games <= dg_nx;
                            game_done  <= 1'b1;
                            if (p1g_nx == WIN_T) begin
                                match_winner <= 2'b01;
                                match_over   <= 1'b1;
                                state        <= MATCH_OVER;
                            end else if (p2g_nx == WIN_T) begin
                                match_winner <= 2'b10;
                                match_over   <= 1'b1;
                                state        <= MATCH_OVER;
                            end else if (total_nx == MAX_T) begin
                                match_winner <= budget_winner;
                                match_over   <= 1'b1;
                                state        <= MATCH_OVER;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end

                MATCH_OVER: ;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
